// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide engine with MTHI/MTLO writes
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic [5:0]       w_op_code_6,
  input  logic             w_start,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_done,
  output logic             w_div_by_zero,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);
  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1a;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1b;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic div_mode, neg_res, neg_rem;
  logic is_mul, is_div, is_signed, idle_start, issue, dz_issue, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0] sum, trial;
  logic ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, hi_nxt, lo_nxt;

  assign is_mul     = w_op_code_6 == SPECIAL_MULT || w_op_code_6 == SPECIAL_MULTU;
  assign is_div     = w_op_code_6 == SPECIAL_DIV  || w_op_code_6 == SPECIAL_DIVU;
  assign is_signed  = w_op_code_6 == SPECIAL_MULT || w_op_code_6 == SPECIAL_DIV;
  assign idle_start = w_start && state == IDLE;
  assign issue      = idle_start && (is_mul || is_div);
  assign dz_issue   = issue && is_div && w_input2_x == '0;
  assign last       = cnt == CW'(WIDTH - 1);
  assign mag_a      = (is_signed && w_input1_x[WIDTH-1]) ? -w_input1_x : w_input1_x;
  assign mag_b      = (is_signed && w_input2_x[WIDTH-1]) ? -w_input2_x : w_input2_x;

  // multiply adds the multiplicand under the low multiplier bit; divide trials the shifted remainder
  assign sum   = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & opnd};
  assign trial = {acc_hi, acc_lo[WIDTH-1]};
  assign ge    = trial >= {1'b0, opnd};

  // sign correction: quotient truncates toward zero, remainder follows the dividend
  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;
  assign hi_nxt   = div_mode ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_nxt   = div_mode ? quo_fix : prod_fix[WIDTH-1:0];

  assign w_busy = state != IDLE;

  // state register
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  // next-state: divide by zero short-circuits the iteration
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = dz_issue ? DZ : issue ? RUN : IDLE;
      RUN:     state_nxt = last ? FIX : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, one iteration per RUN cycle, HI/LO writeback and completion pulses
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      cnt           <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      opnd          <= '0;
      div_mode      <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      w_hi_x        <= '0;
      w_lo_x        <= '0;
      w_done        <= 1'b0;
      w_div_by_zero <= 1'b0;
    end else begin
      w_done        <= state == FIX || state == DZ;
      w_div_by_zero <= state == DZ;
      if (issue) begin
        cnt      <= '0;
        acc_hi   <= '0;
        acc_lo   <= is_div ? mag_a : mag_b;
        opnd     <= is_div ? mag_b : mag_a;
        div_mode <= is_div;
        neg_res  <= is_signed && (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
        neg_rem  <= is_signed && w_input1_x[WIDTH-1];
      end
      if (idle_start && w_op_code_6 == SPECIAL_MTHI) w_hi_x <= w_input1_x;
      if (idle_start && w_op_code_6 == SPECIAL_MTLO) w_lo_x <= w_input1_x;
      if (state == RUN) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= div_mode ? (ge ? trial[WIDTH-1:0] - opnd : trial[WIDTH-1:0]) : sum[WIDTH:1];
        acc_lo <= div_mode ? {acc_lo[WIDTH-2:0], ge} : {sum[0], acc_lo[WIDTH-1:1]};
      end
      if (state == FIX) begin
        w_hi_x <= hi_nxt;
        w_lo_x <= lo_nxt;
      end
    end
  end
endmodule
